// File: rtl/shift_add_mult_if.sv
// Operand/result bundle between the two operand loaders, the multiplier and
// the downstream serializer. master = loader/serializer side, slave = multiplier.
interface shift_add_mult_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0]   x_parallel;
  logic [WIDTH-1:0]   y_parallel;
  logic               fx;
  logic               fy;
  logic [2*WIDTH-1:0] p_out;
  logic               fp;
  logic               busy;

  modport master (
    output x_parallel, y_parallel, fx, fy,
    input  p_out, fp, busy
  );

  modport slave (
    input  x_parallel, y_parallel, fx, fy,
    output p_out, fp, busy
  );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Starts on the rising edge of (fx & fy), one partial-product step per clock,
// holds the product with fp high until the next start.
// Optional feature: define MULT_ZERO_BYPASS_EN to finish a zero-operand
// multiply in one clock without entering RUN.
//
// state  | meaning
// IDLE   | waiting for the first start after reset
// RUN    | shifting/accumulating, busy=1
// DONE   | product held in p_out, fp=1, waiting for the next start
module shift_add_mult #(
  parameter int WIDTH = 12
) (
  input  logic            clk,
  input  logic            reset,
  shift_add_mult_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               rdy_q, rdy_d;

  logic               rdy;
  logic               start;
  logic               zero_op;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;

  assign rdy   = bus.fx & bus.fy;
  assign start = rdy & ~rdy_q;
  assign rdy_d = rdy;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (bus.x_parallel == '0) || (bus.y_parallel == '0);
`else
  assign zero_op = 1'b0;
`endif

  // One partial-product step: conditionally add M into the upper half, then shift right.
  always_comb begin
    sum     = a_q + {1'b0, (q_q[0] ? m_q : {WIDTH{1'b0}})};
    shifted = {sum, q_q} >> 1;
  end

  // Next-state and datapath control; a start from IDLE or DONE reloads the operands.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    count_d = count_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (zero_op) begin
            p_d     = '0;
            state_d = S_DONE;
          end else begin
            m_d     = bus.x_parallel;
            q_d     = bus.y_parallel;
            a_d     = '0;
            count_d = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        a_d     = shifted[2*WIDTH:WIDTH];
        q_d     = shifted[WIDTH-1:0];
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          p_d     = shifted[2*WIDTH-1:0];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and start-edge registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      count_q <= '0;
      p_q     <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      count_q <= count_d;
      p_q     <= p_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.p_out = p_q;
  assign bus.fp    = (state_q == S_DONE);
  assign bus.busy  = (state_q == S_RUN);

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: directed cases plus randomized
// operands compared against plain integer multiplication.
module tb_shift_add_mult;
  localparam int W = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] last_p = '0;

  shift_add_mult_if #(.WIDTH(W)) sam_if ();

  shift_add_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sam_if)
  );

  always #5 clk = ~clk;

  task automatic drop_rdy();
    @(negedge clk);
    sam_if.fx = 1'b0;
    sam_if.fy = 1'b0;
  endtask

  // Raise rdy with operands x,y and follow the multiply until fp rises.
  // glitch: toggle fy mid-run to create a second rdy edge that must be ignored.
  task automatic run_check(input logic [W-1:0] x, input logic [W-1:0] y,
                           input bit glitch, input string name);
    logic [2*W-1:0] exp_p;
    logic [2*W-1:0] prev_p;
    int exp_lat;
    int lat;
    int busy_n;
    bit zero;
    @(negedge clk);
    sam_if.x_parallel = x;
    sam_if.y_parallel = y;
    sam_if.fx = 1'b1;
    sam_if.fy = 1'b1;
    exp_p  = (2*W)'(x) * (2*W)'(y);
    prev_p = sam_if.p_out;
    zero   = (x == 0) || (y == 0);
`ifdef MULT_ZERO_BYPASS_EN
    exp_lat = zero ? 0 : W;
`else
    exp_lat = W;
`endif
    lat = -1;
    busy_n = 0;
    for (int n = 0; n < 4*W; n++) begin
      @(posedge clk);
      #1;
      if (sam_if.busy === 1'b1) busy_n++;
      if (n == 0 && exp_lat != 0) begin
        checks++;
        if (sam_if.fp !== 1'b0) begin
          errors++;
          $display("FAIL %s fp_after_start: got %b expected 0", name, sam_if.fp);
        end
      end
      if (sam_if.fp === 1'b1 && !(n == 0 && exp_lat != 0)) begin
        lat = n;
        break;
      end
      checks++;
      if (sam_if.p_out !== prev_p) begin
        errors++;
        $display("FAIL %s p_out_stable_in_run: got %0h expected %0h", name, sam_if.p_out, prev_p);
      end
      if (n == 3) begin
        sam_if.x_parallel = W'($urandom);
        sam_if.y_parallel = W'($urandom);
      end
      if (glitch && n == 2) sam_if.fy = 1'b0;
      if (glitch && n == 4) sam_if.fy = 1'b1;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy_n != exp_lat) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, exp_lat);
    end
    checks++;
    if (sam_if.p_out !== exp_p) begin
      errors++;
      $display("FAIL %s product: got %0h expected %0h (x=%0d y=%0d)", name, sam_if.p_out, exp_p, x, y);
    end
    last_p = exp_p;
  endtask

  task automatic test_reset();
    sam_if.x_parallel = '0;
    sam_if.y_parallel = '0;
    sam_if.fx = 1'b0;
    sam_if.fy = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (sam_if.p_out !== '0) begin errors++; $display("FAIL reset_p_out: got %0h expected 0", sam_if.p_out); end
    checks++;
    if (sam_if.fp !== 1'b0) begin errors++; $display("FAIL reset_fp: got %b expected 0", sam_if.fp); end
    checks++;
    if (sam_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", sam_if.busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_check(12'd3, 12'd5, 1'b0, "mul_3x5");
    drop_rdy();
    run_check(12'hFFF, 12'hFFF, 1'b0, "mul_fff");
  endtask

  task automatic test_hold();
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sam_if.fp !== 1'b1 || sam_if.busy !== 1'b0 || sam_if.p_out !== last_p) begin
        errors++;
        $display("FAIL hold cycle %0d: fp=%b busy=%b p_out=%0h expected fp=1 busy=0 p_out=%0h",
                 n, sam_if.fp, sam_if.busy, sam_if.p_out, last_p);
      end
    end
  endtask

  task automatic test_restart_from_done();
    @(negedge clk);
    sam_if.fy = 1'b0;
    run_check(12'd100, 12'd200, 1'b0, "restart_100x200");
  endtask

  task automatic test_back_to_back();
    drop_rdy();
    run_check(12'd1234, 12'd3001, 1'b1, "start_ignored_in_run");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sam_if.fp !== 1'b1 || sam_if.p_out !== last_p) begin
      errors++;
      $display("FAIL no_retrigger: fp=%b p_out=%0h expected fp=1 p_out=%0h", sam_if.fp, sam_if.p_out, last_p);
    end
  endtask

  task automatic test_reset_mid_run();
    drop_rdy();
    @(negedge clk);
    sam_if.x_parallel = 12'd55;
    sam_if.y_parallel = 12'd77;
    sam_if.fx = 1'b1;
    sam_if.fy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (sam_if.busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b expected 1", sam_if.busy); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (sam_if.p_out !== '0) begin errors++; $display("FAIL midrun_reset_p_out: got %0h expected 0", sam_if.p_out); end
    checks++;
    if (sam_if.fp !== 1'b0) begin errors++; $display("FAIL midrun_reset_fp: got %b expected 0", sam_if.fp); end
    checks++;
    if (sam_if.busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy: got %b expected 0", sam_if.busy); end
    sam_if.fx = 1'b0;
    sam_if.fy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_check(12'd7, 12'd9, 1'b0, "after_reset_7x9");
  endtask

  task automatic test_zero();
    drop_rdy();
    run_check(12'd0, 12'd123, 1'b0, "zero_x");
    drop_rdy();
    run_check(12'd456, 12'd0, 1'b0, "zero_y");
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < 16; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      if ($urandom_range(4, 0) == 0) x = '0;
      if (i == 5) y = '1;
      drop_rdy();
      run_check(x, y, 1'($urandom_range(1, 0)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_restart_from_done();
    test_back_to_back();
    test_reset_mid_run();
    test_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
